// File: rtl/tdm_frame_rectifier.sv
// Serial-to-parallel TDM frame capture: aligns to frame sync, delivers each
// complete frame as one wide word, and strobes on short frames or lost sync.
module tdm_frame_rectifier #(
   parameter int FRAME_BITS = 256,
   parameter int CNT_W      = 16
) (
   input  logic                  sclk,
   input  logic                  rst,
   input  logic                  sdata,
   input  logic                  sfs,
   output logic                  pvalid,
   output logic [FRAME_BITS-1:0] pdata,
   output logic                  locked,
   output logic                  frame_err,
   output logic [CNT_W-1:0]      frame_cnt
);

   localparam int BW = $clog2(FRAME_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(FRAME_BITS - 1);

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

   state_t                state_q, state_d;
   logic [FRAME_BITS-1:0] sh_q, sh_d;
   logic [FRAME_BITS-1:0] pdata_q, pdata_d;
   logic [BW-1:0]         cnt_q, cnt_d;
   logic [CNT_W-1:0]      fcnt_q, fcnt_d;
   logic                  pvalid_q, pvalid_d;
   logic                  err_q, err_d;

   always_ff @(posedge sclk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         sh_q     <= '0;
         pdata_q  <= '0;
         cnt_q    <= '0;
         fcnt_q   <= '0;
         pvalid_q <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         sh_q     <= sh_d;
         pdata_q  <= pdata_d;
         cnt_q    <= cnt_d;
         fcnt_q   <= fcnt_d;
         pvalid_q <= pvalid_d;
         err_q    <= err_d;
      end
   end

   // Lock is lost only when a frame boundary arrives without its sync pulse.
   always_comb begin
      state_d = state_q;
      case (state_q)
         HUNT:    if (sfs) state_d = RECV;
         RECV:    if (cnt_q == '0 && !sfs) state_d = HUNT;
         default: state_d = HUNT;
      endcase
   end

   always_comb begin
      sh_d     = sh_q;
      pdata_d  = pdata_q;
      cnt_d    = cnt_q;
      fcnt_d   = fcnt_q;
      pvalid_d = 1'b0;
      err_d    = 1'b0;
      if (state_q == RECV || sfs) sh_d = {sh_q[FRAME_BITS-2:0], sdata};
      if (state_q == HUNT) begin
         if (sfs) cnt_d = BW'(1);
      end else if (sfs) begin
         // A sync anywhere but the frame boundary (including the last-bit
         // slot) cuts the current frame short and restarts capture.
         cnt_d = BW'(1);
         if (cnt_q != '0) err_d = 1'b1;
      end else if (cnt_q == '0) begin
         err_d = 1'b1;
         cnt_d = '0;
      end else if (cnt_q == LAST_BIT) begin
         pdata_d  = {sh_q[FRAME_BITS-2:0], sdata};
         pvalid_d = 1'b1;
         fcnt_d   = fcnt_q + CNT_W'(1);
         cnt_d    = '0;
      end else begin
         cnt_d = cnt_q + BW'(1);
      end
   end

   always_comb begin
      locked    = (state_q == RECV);
      pvalid    = pvalid_q;
      frame_err = err_q;
      pdata     = pdata_q;
      frame_cnt = fcnt_q;
   end

endmodule

// File: tb/tb_tdm_frame_rectifier.sv
// Directed bench for tdm_frame_rectifier: 256-bit frames on one instance and
// 8-bit frames with a 2-bit counter on a second instance.
module tb_tdm_frame_rectifier;

   // ---------------- clock / reset ----------------
   logic sclk = 1'b0;
   logic rst  = 1'b1;
   always #5 sclk = ~sclk;

   logic         sdata = 1'b0, sfs = 1'b0;
   logic         pvalid, locked, frame_err;
   logic [255:0] pdata;
   logic [15:0]  frame_cnt;

   logic         sdata8 = 1'b0, sfs8 = 1'b0;
   logic         pvalid8, locked8, frame_err8;
   logic [7:0]   pdata8;
   logic [1:0]   frame_cnt8;

   tdm_frame_rectifier #(.FRAME_BITS(256), .CNT_W(16)) dut (
      .sclk(sclk), .rst(rst), .sdata(sdata), .sfs(sfs),
      .pvalid(pvalid), .pdata(pdata), .locked(locked),
      .frame_err(frame_err), .frame_cnt(frame_cnt)
   );

   tdm_frame_rectifier #(.FRAME_BITS(8), .CNT_W(2)) dut8 (
      .sclk(sclk), .rst(rst), .sdata(sdata8), .sfs(sfs8),
      .pvalid(pvalid8), .pdata(pdata8), .locked(locked8),
      .frame_err(frame_err8), .frame_cnt(frame_cnt8)
   );

   // ---------------- scoreboard counters ----------------
   int checks = 0, failures = 0;
   int cyc = 0, pv_n = 0, err_n = 0, both_n = 0, last_pv = 0;

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge sclk);
      #1;
      cyc++;
      if (pvalid) begin
         pv_n++;
         last_pv = cyc;
      end
      if (frame_err) err_n++;
      if (pvalid && frame_err) both_n++;
   endtask

   // Sends the first n bits of a frame, MSB first, sync on the first bit.
   task automatic send_bits(input logic [255:0] data, input int n);
      for (int i = 0; i < n; i++) begin
         sdata = data[255-i];
         sfs   = (i == 0);
         tick();
      end
      sfs = 1'b0;
   endtask

   task automatic send_full(input string tag, input logic [255:0] data, input logic [15:0] exp_cnt);
      int pv0;
      pv0 = pv_n;
      send_bits(data, 256);
      check({tag, "_pvalid"},   256'(pvalid), 256'(1));
      check({tag, "_pv_once"},  256'(pv_n - pv0), 256'(1));
      check({tag, "_pdata"},    pdata, data);
      check({tag, "_frame_cnt"}, 256'(frame_cnt), 256'(exp_cnt));
   endtask

   logic [255:0] fa, fb, fc, fd, fe, fx, f3c;
   logic [7:0]   small_frames [5];
   logic [1:0]   small_cnt_exp [5];
   logic [7:0]   cur8;
   int           pa, pb, pv0, err0;

   initial begin
      f3c = {32{8'h3C}};
      fa  = {32{8'hA5}};
      for (int i = 0; i < 32; i++) fb[255-8*i -: 8] = 8'(i);
      fc  = {32{8'h96}};
      fd  = {32{8'hE1}};
      fe  = {16{16'h1234}};
      fx  = {32{8'hFF}};
      small_frames  = '{8'h81, 8'h7E, 8'hC3, 8'h24, 8'hF0};
      small_cnt_exp = '{2'd1, 2'd2, 2'd3, 2'd0, 2'd1};

      // Reset held for a few cycles with activity on the inputs.
      sdata = 1'b1; sfs = 1'b1;
      repeat (3) tick();
      check("rst_pvalid", 256'(pvalid), 256'(0));
      check("rst_locked", 256'(locked), 256'(0));
      check("rst_err",    256'(frame_err), 256'(0));
      check("rst_pdata",  pdata, 256'(0));
      check("rst_cnt",    256'(frame_cnt), 256'(0));
      sfs = 1'b0; sdata = 1'b0;
      rst = 1'b0;
      tick();
      check("post_rst_locked", 256'(locked), 256'(0));

      // Garbage without sync is ignored.
      for (int i = 0; i < 7; i++) begin
         sdata = 1'(i & 1);
         tick();
      end
      check("hunt_locked", 256'(locked), 256'(0));

      // Single frame.
      sdata = f3c[255]; sfs = 1'b1;
      tick();
      sfs = 1'b0;
      check("lock_after_sync", 256'(locked), 256'(1));
      check("no_early_pvalid", 256'(pv_n), 256'(0));
      for (int i = 1; i < 256; i++) begin
         sdata = f3c[255-i];
         tick();
      end
      check("single_pvalid", 256'(pvalid), 256'(1));
      check("single_pdata",  pdata, f3c);
      check("single_cnt",    256'(frame_cnt), 256'(1));
      check("single_locked", 256'(locked), 256'(1));

      // Back-to-back frames.
      err0 = err_n;
      send_full("frame_a", fa, 16'd2);
      pa = last_pv;
      send_full("frame_b", fb, 16'd3);
      pb = last_pv;
      check("b2b_spacing", 256'(pb - pa), 256'(256));
      check("b2b_no_err",  256'(err_n - err0), 256'(0));

      // Short frame: sync after 100 bits.
      pv0 = pv_n;
      send_bits(fx, 100);
      sdata = fc[255]; sfs = 1'b1;
      tick();
      sfs = 1'b0;
      check("short_err",    256'(frame_err), 256'(1));
      check("short_no_pv",  256'(pv_n - pv0), 256'(0));
      check("short_pdata",  pdata, fb);
      check("short_locked", 256'(locked), 256'(1));
      err0 = err_n;
      for (int i = 1; i < 256; i++) begin
         sdata = fc[255-i];
         tick();
      end
      check("after_short_pdata", pdata, fc);
      check("after_short_cnt",   256'(frame_cnt), 256'(4));
      check("short_err_once",    256'(err_n - err0), 256'(0));

      // Missing sync at the next frame boundary.
      sdata = 1'b1; sfs = 1'b0;
      tick();
      check("miss_err",    256'(frame_err), 256'(1));
      check("miss_locked", 256'(locked), 256'(0));
      tick();
      check("miss_err_pulse", 256'(frame_err), 256'(0));
      pv0 = pv_n;
      for (int i = 0; i < 300; i++) begin
         sdata = 1'($urandom_range(0, 1));
         tick();
      end
      check("miss_no_pv",     256'(pv_n - pv0), 256'(0));
      check("miss_hunt_lock", 256'(locked), 256'(0));
      send_full("frame_d", fd, 16'd5);

      // Sync coincident with the last bit of a frame is a short frame.
      pv0 = pv_n;
      send_bits(fx, 255);
      sdata = fe[255]; sfs = 1'b1;
      tick();
      sfs = 1'b0;
      check("lastbit_err",   256'(frame_err), 256'(1));
      check("lastbit_no_pv", 256'(pv_n - pv0), 256'(0));
      check("lastbit_pdata", pdata, fd);
      for (int i = 1; i < 256; i++) begin
         sdata = fe[255-i];
         tick();
      end
      check("frame_e_pdata", pdata, fe);
      check("frame_e_cnt",   256'(frame_cnt), 256'(6));
      check("pv_err_overlap", 256'(both_n), 256'(0));

      // Reset in the middle of a frame.
      send_bits(fa, 120);
      #2 rst = 1'b1;
      #1;
      check("midrst_locked", 256'(locked), 256'(0));
      check("midrst_pdata",  pdata, 256'(0));
      check("midrst_cnt",    256'(frame_cnt), 256'(0));
      pv0 = pv_n;
      sdata = 1'b1;
      repeat (3) tick();
      rst = 1'b0;
      for (int i = 0; i < 140; i++) tick();
      check("midrst_no_pv",   256'(pv_n - pv0), 256'(0));
      check("midrst_hunting", 256'(locked), 256'(0));
      check("midrst_cnt_hold", 256'(frame_cnt), 256'(0));
      sdata = 1'b0;

      // Small frames: garbage then five back-to-back frames, counter wraps.
      for (int i = 0; i < 6; i++) begin
         sdata8 = 1'(i % 3 != 1);
         tick();
      end
      check("s8_hunt_locked", 256'(locked8), 256'(0));
      check("s8_hunt_cnt",    256'(frame_cnt8), 256'(0));
      for (int k = 0; k < 5; k++) begin
         cur8 = small_frames[k];
         for (int i = 0; i < 8; i++) begin
            sdata8 = cur8[7-i];
            sfs8   = (i == 0);
            tick();
         end
         sfs8 = 1'b0;
         check($sformatf("s8_pvalid_%0d", k), 256'(pvalid8), 256'(1));
         check($sformatf("s8_pdata_%0d", k),  256'(pdata8), 256'(cur8));
         check($sformatf("s8_cnt_%0d", k),    256'(frame_cnt8), 256'(small_cnt_exp[k]));
         check($sformatf("s8_msb_%0d", k),    256'(pdata8[7]), 256'(cur8[7]));
         check($sformatf("s8_err_%0d", k),    256'(frame_err8), 256'(0));
      end

      // ---------------- report ----------------
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
